data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum number of REQ-state cycles to wait for mem_ack_i before the access is aborted.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: value returned on data_o for an aborted or rejected read.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 MemRead_i  input  1  CPU read request; held stable while stall_o=1.
REQ-006 MemWrite_i  input  1  CPU write request; held stable while stall_o=1.
REQ-007 addr_i  input  32  CPU byte address (the ALU result).
REQ-008 data_i  input  32  CPU write data (the rt register value).
REQ-009 data_o  output  32  read data returned to the CPU write-back path.
REQ-010 stall_o  output  1  freezes the CPU program counter and pipeline while high.
REQ-011 err_o  output  1  sticky error flag.
REQ-012 mem_req_o  output  1  memory-side request strobe.
REQ-013 mem_we_o  output  1  memory-side write enable, valid with mem_req_o.
REQ-014 mem_addr_o  output  32  memory-side word address, equal to the latched addr_i.
REQ-015 mem_wdata_o  output  32  memory-side write data.
REQ-016 mem_ack_i  input  1  memory-side completion pulse; mem_rdata_i is valid in the same cycle.
REQ-017 mem_rdata_i  input  32  memory-side read data.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, DONE; it SHALL enter IDLE on reset.
REQ-019 IDLE: stall_o SHALL be combinationally 1 whenever MemRead_i or MemWrite_i is 1, otherwise 0.
REQ-020 IDLE with a request: the block SHALL latch addr_i, data_i and we=MemWrite_i, clear the timeout counter, and go to REQ.
REQ-021 REQ: mem_req_o SHALL be 1 (registered), mem_we_o shall equal we, and stall_o shall be 1.
REQ-022 REQ with mem_ack_i=1: the block SHALL capture mem_rdata_i (reads only) and go to DONE.
REQ-023 REQ without an ack: the counter SHALL increment; when the counter reaches TIMEOUT_CYC-1 with no ack, the block SHALL go to DONE, set err_o, and load the read data with ERR_DATA.
REQ-024 An ack arriving in the same cycle as the timeout SHALL win: normal completion, no error.
REQ-025 DONE: stall_o SHALL be 0 and mem_req_o 0 for exactly one cycle; data_o shall present the captured data; the next state shall be IDLE.
REQ-026 Outside DONE, data_o SHALL hold its last value.
REQ-027 MemRead_i and MemWrite_i both 1: the access SHALL be treated as a write and err_o shall be set.
REQ-028 addr_i[1:0] != 0: no memory access SHALL occur (mem_req_o stays 0); the block shall go IDLE->DONE, set err_o, and return ERR_DATA for reads.
REQ-029 mem_ack_i in IDLE or DONE SHALL be ignored.
REQ-030 err_o SHALL stay set until reset.
REQ-031 Minimum access: request in cycle 0, mem_req_o high in cycle 1, ack in cycle 1, DONE in cycle 2; stall_o is high in cycles 0-1.

Reset
REQ-032 On rst_i=1 at a clock edge, the block SHALL set state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, data_o=0, err_o=0, and counter=0, regardless of the current state.
REQ-033 A reset asserted mid-REQ SHALL abandon the access; mem_req_o SHALL be 0 from the cycle after the edge.

Verification
REQ-034 Read addr 0x10 with ack after 3 REQ cycles and rdata 0x12345678 -> stall_o high for 4 cycles, then a DONE cycle with data_o=0x12345678 and err_o=0.
REQ-035 Write addr 0x20 with data 0xA5A5A5A5 and ack in the first REQ cycle -> mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0xA5A5A5A5; stall_o high for 2 cycles; no error.
REQ-036 Read with TIMEOUT_CYC=4 and no ack -> mem_req_o high for exactly 4 cycles, then DONE with data_o=0xDEADBEEF and err_o=1 (sticky).
REQ-037 Read addr 0x13 -> mem_req_o is never asserted, the next cycle is DONE with data_o=0xDEADBEEF, and err_o=1.
REQ-038 Reset asserted during the 2nd REQ cycle -> all outputs at reset values on the next cycle; a subsequent read completes normally.
REQ-039 Ack coincident with the final timeout cycle, rdata 0x1 -> data_o=0x1 and err_o=0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: turns CPU load/store requests into a req/ack
// memory handshake, stalling the CPU until the access completes or is aborted.
module data_mem_ctrl #(
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_req;
    logic             r_mem_we;
    logic             r_err;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      r_data;

    logic w_access;
    logic w_misaligned;
    logic w_timeout;

    assign w_access     = MemRead_i | MemWrite_i;
    assign w_misaligned = (addr_i[1:0] != 2'b00);
    assign w_timeout    = (r_cnt == CNT_LAST);

    assign data_o      = r_data;
    assign err_o       = r_err;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    // Stall must rise in the same cycle the CPU presents the request, so it is
    // decoded from the live inputs while idle rather than registered.
    always_comb begin
        // NOTE: default first so every path assigns stall_o and no latch is inferred.
        stall_o = 1'b0;
        case (r_state)
            S_IDLE:  stall_o = w_access;
            S_REQ:   stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_data      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_mem_addr  <= addr_i;
                        r_mem_wdata <= data_i;
                        r_mem_we    <= MemWrite_i;
                        r_cnt       <= '0;
                        if (MemRead_i && MemWrite_i)
                            r_err <= 1'b1;
                        // A misaligned access never reaches memory.
                        if (w_misaligned) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                            if (!MemWrite_i)
                                r_data <= ERR_DATA;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (mem_ack_i) begin
                        if (!r_mem_we)
                            r_data <= mem_rdata_i;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (!r_mem_we)
                            r_data <= ERR_DATA;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: expected completions are queued when a
// request is driven and compared when the controller reaches its DONE cycle.
module tb_data_mem_ctrl;

    localparam int          TO_CYC = 4;
    localparam logic [31:0] ERRD   = 32'hDEADBEEF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        stall_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    data_mem_ctrl #(
        .TIMEOUT_CYC (TO_CYC),
        .ERR_DATA    (ERRD)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        int          stall_cyc;
        int          req_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i      = 1'b1;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        mem_ack_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_data"},  data_o,      32'h0);
        check({tag, "_err"},   err_o,       32'h0);
        check({tag, "_req"},   mem_req_o,   32'h0);
        check({tag, "_we"},    mem_we_o,    32'h0);
        check({tag, "_addr"},  mem_addr_o,  32'h0);
        check({tag, "_wdata"}, mem_wdata_o, 32'h0);
        check({tag, "_stall"}, stall_o,     32'h0);
    endtask

    // ack_at = index of the REQ cycle carrying the ack (0 = never ack).
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_at, input logic [31:0] rdata,
                              input logic [31:0] exp_data, input logic exp_err,
                              input int exp_stall, input int exp_req);
        int   stall_n;
        int   req_n;
        int   cyc;
        exp_t e;
        stall_n = 0;
        req_n   = 0;
        cyc     = 0;
        sb_q.push_back('{tag, exp_data, exp_err, exp_stall, exp_req});
        @(negedge clk_i);
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = addr;
        data_i     = wdata;
        forever begin
            #1;
            if (!stall_o) break;
            stall_n++;
            if (mem_req_o) begin
                req_n++;
                if (req_n == 1) begin
                    check({tag, "_mem_we"},    mem_we_o,    {31'b0, wr});
                    check({tag, "_mem_addr"},  mem_addr_o,  addr);
                    check({tag, "_mem_wdata"}, mem_wdata_o, wdata);
                end
                mem_ack_i = (req_n == ack_at);
            end else begin
                mem_ack_i = 1'b0;
            end
            mem_rdata_i = mem_ack_i ? rdata : 32'h0BAD_F00D;
            @(negedge clk_i);
            cyc++;
            if (cyc > 40) begin
                check({tag, "_done_timeout"}, 32'h0, 32'h1);
                break;
            end
        end
        mem_ack_i  = 1'b0;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        e = sb_q.pop_front();
        check({e.tag, "_data"},      data_o,    e.data);
        check({e.tag, "_err"},       err_o,     {31'b0, e.err});
        check({e.tag, "_done_req"},  mem_req_o, 32'h0);
        check({e.tag, "_stall_cyc"}, stall_n,   e.stall_cyc);
        check({e.tag, "_req_cyc"},   req_n,     e.req_cyc);
        @(negedge clk_i);
        #1;
        check({e.tag, "_hold_data"}, data_o, e.data);
        check({e.tag, "_hold_err"},  err_o,  {31'b0, e.err});
    endtask

    initial begin
        do_reset();
        #1;
        check_reset_state("reset");

        run_access("rd_ack3",   1'b1, 1'b0, 32'h10, 32'h0,        3, 32'h12345678, 32'h12345678, 1'b0, 4, 3);
        run_access("wr_ack1",   1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1, 32'h0,        32'h12345678, 1'b0, 2, 1);
        run_access("rd_ack_to", 1'b1, 1'b0, 32'h40, 32'h0,        4, 32'h00000001, 32'h00000001, 1'b0, 5, 4);
        run_access("rd_ack2",   1'b1, 1'b0, 32'h44, 32'h0,        2, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3, 2);

        // Reset during the second REQ cycle.
        @(negedge clk_i);
        MemRead_i = 1'b1;
        addr_i    = 32'h50;
        repeat (2) @(negedge clk_i);
        #1;
        check("mid_rst_in_req", mem_req_o, 32'h1);
        rst_i     = 1'b1;
        MemRead_i = 1'b0;
        @(negedge clk_i);
        #1;
        check_reset_state("mid_rst");
        rst_i = 1'b0;

        run_access("rd_after_rst", 1'b1, 1'b0, 32'h60, 32'h0, 1, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 2, 1);
        run_access("rd_timeout",   1'b1, 1'b0, 32'h70, 32'h0, 0, 32'h0,        ERRD,         1'b1, 5, 4);
        run_access("rd_sticky",    1'b1, 1'b0, 32'h74, 32'h0, 1, 32'h00000011, 32'h00000011, 1'b1, 2, 1);

        do_reset();
        run_access("rd_misalign", 1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h77777777, ERRD, 1'b1, 1, 0);

        do_reset();
        run_access("rd_and_wr", 1'b1, 1'b1, 32'h80, 32'h5A5A5A5A, 1, 32'h99999999, 32'h0, 1'b1, 2, 1);

        check("sb_empty", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
